irq_pending_arbiter: RTL and testbench
======================================

IRQ_PENDING_ARBITER -- requirements
Module: irq_pending_arbiter

Interface
REQ-001 The block SHALL have no parameters; request width is fixed at 4 and ID width at 2.
REQ-002 clk  input  1  sole clock; all state SHALL change only on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  request lines, synchronous to clk; a 0->1 transition on req[i] is one event for line i.
REQ-005 mask  input  4  enable per line; mask[i]=0 blocks line i from being issued but does not block latching it.
REQ-006 ovr_clr  input  1  when 1 at a clock edge, SHALL clear all overrun bits.
REQ-007 irq_valid  output  1  an encoded request is being presented.
REQ-008 irq_id  output  2  encoded line number, 3 highest priority; meaningful only while irq_valid=1.
REQ-009 irq_ready  input  1  consumer accepts; a transfer occurs at an edge where irq_valid=1 and irq_ready=1.
REQ-010 pending  output  4  registered sticky pending bits.
REQ-011 overrun  output  4  registered sticky flags: an event arrived on a line whose pending bit was already set.

Function
REQ-012 The block SHALL register req into req_q each cycle; the event for line i is req[i]=1 and req_q[i]=0.
REQ-013 An event on line i SHALL set pending[i] at that edge: if req rises before edge k, pending[i]=1 after edge k.
REQ-014 An event on line i while pending[i]=1 and the bit is not being cleared at the same edge SHALL set overrun[i]; pending[i] stays 1.
REQ-015 The output stage SHALL have two states, IDLE (irq_valid=0) and HOLD (irq_valid=1).
REQ-016 IDLE: if (pending & mask) is non-zero at an edge, the block SHALL load irq_id with the highest set index, go to HOLD and clear that pending bit at the same edge.
REQ-017 IDLE with (pending & mask)=0: remain IDLE; irq_id holds its previous value.
REQ-018 HOLD with irq_ready=0: irq_valid and irq_id SHALL stay stable.
REQ-019 HOLD with irq_ready=1: if (pending & mask) is non-zero, reload the next winner and clear its pending bit (back-to-back, no bubble); otherwise go to IDLE.
REQ-020 Latency: a lone event before edge k with output IDLE and the line unmasked SHALL give irq_valid=1 after edge k+1.
REQ-021 Same-edge event and clear on one line: set SHALL win, pending stays 1 and overrun is not set.
REQ-022 Priority SHALL be decided only from pending & mask at the load edge; new events at that edge take part from the next edge.
REQ-023 A line masked while pending SHALL keep its pending bit until unmasked and issued.
REQ-024 ovr_clr and a new overrun on the same edge: set SHALL win for that line.

Reset
REQ-025 While rst_n=0: irq_valid=0, irq_id=2'b00, pending=4'b0000, overrun=4'b0000, req_q=4'b0000, state IDLE.
REQ-026 An event or handshake in progress when rst_n falls SHALL be discarded; there is no recovery of lost requests.
REQ-027 req already high at reset release SHALL count as an event at the first edge (req_q reset to 0).

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, HOLD) and the constants NUM_REQ=4 and ID_W=2.
REQ-029 The combinational winner selection SHALL be one sub-module, irq_prio_enc4: 4-bit input, 2-bit id and 1-bit any output, with no X output when the input is all zero.

Verification
REQ-030 Reset, then pulse req=4'b0100 for one cycle with mask=4'hF and irq_ready=1 -> pending=0100 after edge k, irq_valid=1 and irq_id=2 after k+1, pending=0000, irq_valid=0 after k+2.
REQ-031 req=4'b1011 in one cycle with irq_ready=1 -> ids 3, 1, 0 on consecutive cycles with irq_valid continuously 1, then IDLE.
REQ-032 irq_ready=0, event on line 2, then irq_ready=0 for 5 cycles -> irq_id=2 stable for all cycles; after ready=1 one transfer, then irq_valid=0.
REQ-033 mask=4'b0111, event on line 3 then line 1 -> id 1 issued and pending[3] stays 1; set mask[3]=1 -> id 3 issued.
REQ-034 Line 0 pending under mask=0, second event on line 0 -> overrun=0001; ovr_clr=1 -> overrun=0000; ovr_clr on the same edge as a new overrun -> overrun stays 0001.
REQ-035 rst_n low in HOLD with pending=1010 -> irq_valid, pending and overrun are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/irq_pending_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// irq_pending_arbiter_pkg
// Shared definitions for the pending-interrupt arbiter: request/ID widths,
// the output-stage state encoding and a small ID-to-one-hot helper.
// -----------------------------------------------------------------------------
package irq_pending_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    // Output stage: IDLE presents nothing, HOLD presents irq_id until accepted.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot mask of the line addressed by id, used to clear a pending bit.
    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        logic [NUM_REQ-1:0] onehot;
        onehot     = '0;
        onehot[id] = 1'b1;
        return onehot;
    endfunction

endpackage : irq_pending_arbiter_pkg

// File: rtl/irq_prio_enc4.sv
// -----------------------------------------------------------------------------
// irq_prio_enc4
// Fixed-priority encoder, index 3 highest. Purely combinational.
//   in   [3:0]  candidate lines (pending & mask)
//   id   [1:0]  highest set index; 2'b00 when in is all zero
//   any         at least one bit of in is set
// -----------------------------------------------------------------------------
module irq_prio_enc4
    import irq_pending_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] in,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    // NOTE: every output gets a default before the priority chain so no path
    // leaves it unassigned; that keeps this block latch-free and X-free.
    always_comb begin
        id  = 2'd0;
        any = |in;
        if (in[3]) begin
            id = 2'd3;
        end else if (in[2]) begin
            id = 2'd2;
        end else if (in[1]) begin
            id = 2'd1;
        end else begin
            id = 2'd0;
        end
    end

endmodule : irq_prio_enc4

// File: rtl/irq_pending_arbiter.sv
// -----------------------------------------------------------------------------
// irq_pending_arbiter
// Latches rising edges on four request lines into sticky pending bits, flags
// overruns (a new event on an already-pending line) and hands the highest
// priority unmasked pending line to a consumer over a valid/ready interface.
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req  [3:0] request lines; a 0->1 transition is one event
//   mask [3:0] per-line issue enable (masked lines still latch)
//   ovr_clr    clears all overrun flags (a same-edge new overrun wins)
//   irq_valid  an encoded request is presented
//   irq_id [1:0] presented line number, 3 highest priority
//   irq_ready  consumer accepts when irq_valid=1
//   pending [3:0] sticky pending bits
//   overrun [3:0] sticky overrun flags
// -----------------------------------------------------------------------------
module irq_pending_arbiter
    import irq_pending_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               ovr_clr,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ready,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] overrun
);

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] evt;
    logic [NUM_REQ-1:0] clr_vec;
    logic [NUM_REQ-1:0] pending_nxt;
    logic [NUM_REQ-1:0] overrun_nxt;
    logic [ID_W-1:0]    win_id;
    logic               win_any;
    logic               load;

    assign evt = req & ~req_q;

    // Winner is chosen from the registered pending bits only, so an event
    // arriving at the load edge competes from the following edge.
    irq_prio_enc4 u_prio_enc (
        .in  (pending & mask),
        .id  (win_id),
        .any (win_any)
    );

    // Output-stage next state. A load happens from IDLE whenever something is
    // eligible, and from HOLD only when the current ID is being accepted,
    // which gives back-to-back transfers without an idle bubble.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (irq_ready) begin
                    if (win_any) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A new event on the line being cleared re-sets it (set wins) and is not
    // an overrun because the previous request was just consumed.
    always_comb begin
        clr_vec     = load ? id_to_onehot(win_id) : '0;
        pending_nxt = (pending & ~clr_vec) | evt;
        overrun_nxt = (ovr_clr ? '0 : overrun) | (evt & pending & ~clr_vec);
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_q resets to zero so a line already high at reset release counts as
    // an event on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
            overrun <= '0;
            irq_id  <= '0;
        end else begin
            req_q   <= req;
            pending <= pending_nxt;
            overrun <= overrun_nxt;
            if (load) begin
                irq_id <= win_id;
            end
        end
    end

    assign irq_valid = (state == HOLD);

endmodule : irq_pending_arbiter

// File: tb/tb_irq_pending_arbiter.sv
// -----------------------------------------------------------------------------
// tb_irq_pending_arbiter
// Directed bench for irq_pending_arbiter. Expected transfer IDs are queued by
// the stimulus; a negedge monitor pops and compares on every accepted transfer.
// Register-level expectations are compared with check() one tick after edges.
// -----------------------------------------------------------------------------
module tb_irq_pending_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ovr_clr;
    logic       irq_valid;
    logic [1:0] irq_id;
    logic       irq_ready;
    logic [3:0] pending;
    logic [3:0] overrun;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q[$];

    irq_pending_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .ovr_clr   (ovr_clr),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .irq_ready (irq_ready),
        .pending   (pending),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a transfer is seen at the negedge before the edge
    // where it completes.
    always @(negedge clk) begin
        if (rst_n && irq_valid && irq_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL xfer_unexpected: got id %0d expected no transfer at %0t", irq_id, $time);
            end else begin
                logic [1:0] e;
                e = exp_q.pop_front();
                if (irq_id !== e) begin
                    failures++;
                    $display("FAIL xfer_id: got %0d expected %0d at %0t", irq_id, e, $time);
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        req       = 4'b0000;
        mask      = 4'hF;
        ovr_clr   = 1'b0;
        irq_ready = 1'b1;
        #12;
        check("rst_valid",   irq_valid, 1'b0);
        check("rst_id",      irq_id,    2'd0);
        check("rst_pending", pending,   4'h0);
        check("rst_overrun", overrun,   4'h0);
        step();
        rst_n = 1'b1;
        step();

        // Single event on line 2, unmasked, consumer always ready.
        req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        check("t1_pend_k", pending, 4'b0100);
        check("t1_valid_k", irq_valid, 1'b0);
        req = 4'b0000;
        step();
        check("t1_valid_k1", irq_valid, 1'b1);
        check("t1_id_k1", irq_id, 2'd2);
        check("t1_pend_k1", pending, 4'b0000);
        step();
        check("t1_valid_k2", irq_valid, 1'b0);

        // Three simultaneous events drain back-to-back in priority order.
        req = 4'b1011;
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        step();
        check("t2_pend", pending, 4'b1011);
        req = 4'b0000;
        step();
        check("t2_v3", irq_valid, 1'b1);
        check("t2_id3", irq_id, 2'd3);
        step();
        check("t2_v1", irq_valid, 1'b1);
        check("t2_id1", irq_id, 2'd1);
        step();
        check("t2_v0", irq_valid, 1'b1);
        check("t2_id0", irq_id, 2'd0);
        step();
        check("t2_idle", irq_valid, 1'b0);

        // Stall: output held stable while irq_ready=0.
        irq_ready = 1'b0;
        req = 4'b0100;
        exp_q.push_back(2'd2);
        step();
        req = 4'b0000;
        step();
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", irq_valid, 1'b1);
            check("t3_hold_id", irq_id, 2'd2);
            step();
        end
        irq_ready = 1'b1;
        step();
        check("t3_done", irq_valid, 1'b0);

        // Masked line 3 stays pending while line 1 is served.
        mask = 4'b0111;
        req = 4'b1000;
        step();
        check("t4_pend3", pending, 4'b1000);
        req = 4'b0000;
        step();
        check("t4_masked_idle", irq_valid, 1'b0);
        req = 4'b0010;
        exp_q.push_back(2'd1);
        step();
        check("t4_pend31", pending, 4'b1010);
        req = 4'b0000;
        step();
        check("t4_id1", irq_id, 2'd1);
        check("t4_pend_keep3", pending, 4'b1000);
        step();
        check("t4_idle", irq_valid, 1'b0);
        mask = 4'hF;
        exp_q.push_back(2'd3);
        step();
        check("t4_id3_valid", irq_valid, 1'b1);
        check("t4_id3", irq_id, 2'd3);
        check("t4_pend_empty", pending, 4'b0000);
        step();
        check("t4_idle2", irq_valid, 1'b0);

        // Overrun set, clear, and clear colliding with a new overrun.
        mask = 4'b1110;
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        req = 4'b0001;
        step();
        check("t5_ovr_set", overrun, 4'b0001);
        check("t5_pend_stays", pending, 4'b0001);
        req = 4'b0000;
        ovr_clr = 1'b1;
        step();
        check("t5_ovr_clr", overrun, 4'b0000);
        req = 4'b0001;
        step();
        check("t5_ovr_set_wins", overrun, 4'b0001);
        req = 4'b0000;
        step();
        ovr_clr = 1'b0;
        check("t5_ovr_clr2", overrun, 4'b0000);

        // Event on line 0 at the edge that clears it: set wins, no overrun.
        mask = 4'hF;
        req = 4'b0001;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        step();
        check("t6_valid", irq_valid, 1'b1);
        check("t6_pend_set_wins", pending, 4'b0001);
        check("t6_no_ovr", overrun, 4'b0000);
        req = 4'b0000;
        step();
        check("t6_b2b_valid", irq_valid, 1'b1);
        check("t6_b2b_id", irq_id, 2'd0);
        check("t6_pend_clr", pending, 4'b0000);
        step();
        check("t6_idle", irq_valid, 1'b0);
        check("sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while holding with pending=1010.
        irq_ready = 1'b0;
        req = 4'b1010;
        step();
        req = 4'b0000;
        step();
        req = 4'b1000;
        step();
        check("t7_pre_pend", pending, 4'b1010);
        check("t7_pre_valid", irq_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_valid", irq_valid, 1'b0);
        check("t7_async_pend", pending, 4'b0000);
        check("t7_async_ovr", overrun, 4'b0000);
        check("t7_async_id", irq_id, 2'd0);

        // req already high when reset releases counts as an event.
        req = 4'b0001;
        irq_ready = 1'b1;
        step();
        rst_n = 1'b1;
        exp_q.push_back(2'd0);
        step();
        check("t8_pend", pending, 4'b0001);
        step();
        check("t8_valid", irq_valid, 1'b1);
        check("t8_id", irq_id, 2'd0);
        step();
        check("t8_idle", irq_valid, 1'b0);
        check("sb_empty_end", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion expected finish by %0t", $time);
        $fatal(1, "timeout");
    end

endmodule : tb_irq_pending_arbiter
